// File: rtl/frame_pkg.sv
// Shared frame-path constants and types for the frame store read side.
package frame_pkg;

    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned V_ACTIVE    = 480;
    localparam int unsigned F_SIZE      = H_ACTIVE * V_ACTIVE;
    localparam int unsigned ADDR_FRAME  = 19;
    localparam int unsigned DATA_WIDTH  = 8;
    localparam int unsigned BLK         = 20;
    localparam int unsigned PAD         = 4;

    // BRAM read latency supported by the read pipeline and FLUSH counter
    localparam int unsigned RD_LAT_MAX  = 4;
    localparam int unsigned FLUSH_CNT_W = $clog2(RD_LAT_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        FLUSH,
        DRAIN
    } frc_state_t;

    // Per-read tag travelling alongside the BRAM access
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } frc_tag_t;

endpackage

// File: rtl/frc_lat_pipe.sv
// READ_LAT-deep tag delay line; re-times BRAM data into the pixel stream.
module frc_lat_pipe
    import frame_pkg::*;
#(
    parameter int unsigned LAT    = 1,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_in_100,
    input  logic              arst_n,
    input  frc_tag_t          rd_tag,
    input  logic [DATA_W-1:0] rdata,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix,
    output logic              frame_start,
    output logic              frame_end
);

    frc_tag_t tag_sr [LAT];
    frc_tag_t tap_c;

    // Stage LAT-1 lines up with the cycle the BRAM presents the data
    assign tap_c = tag_sr[LAT-1];

    always_ff @(posedge clk_in_100 or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < int'(LAT); i++) begin
                tag_sr[i] <= '0;
            end
            pix_valid   <= 1'b0;
            pix         <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            tag_sr[0] <= rd_tag;
            for (int i = 1; i < int'(LAT); i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
            pix_valid   <= tap_c.vld;
            frame_start <= tap_c.vld & tap_c.first;
            frame_end   <= tap_c.vld & tap_c.last;
            if (tap_c.vld) begin
                pix <= rdata;
            end
        end
    end

endmodule

// File: rtl/frame_read_ctrl.sv
// Frame-read sequencer: one sequential BRAM sweep per accepted bank swap.
// Define FRC_TIMEOUT_EN to add the DRAIN watchdog and sticky timeout_o.
module frame_read_ctrl
    import frame_pkg::*;
#(
    parameter int unsigned F_SIZE      = frame_pkg::F_SIZE,
    parameter int unsigned ADDR_W      = ADDR_FRAME,
    parameter int unsigned DATA_W      = DATA_WIDTH,
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned TIMEOUT_CYC = 65536
) (
    input  logic              clk_in_100,
    input  logic              arst_n,
    input  logic              en_i,
    input  logic              swap_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              rd_en_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              pix_valid_o,
    output logic [DATA_W-1:0] pix_o,
    output logic              frame_start_o,
    output logic              frame_end_o,
    input  logic              done_i,
    output logic              busy_o,
    output logic [15:0]       drop_cnt_o,
    output logic              timeout_o
);

    localparam logic [ADDR_W-1:0]      LAST_ADDR  = ADDR_W'(F_SIZE - 1);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(READ_LAT - 1);

    if (READ_LAT < 1 || READ_LAT > RD_LAT_MAX || TIMEOUT_CYC == 0 ||
        (64'(1) << ADDR_W) < 64'(F_SIZE)) begin : g_cfg_err
        $error("frame_read_ctrl: illegal READ_LAT/ADDR_W/F_SIZE/TIMEOUT_CYC");
    end

    frc_state_t             state;
    logic                   swap_q;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic                   swap_rise_c;
    logic                   accept_c;
    frc_tag_t               rd_tag_c;

    assign swap_rise_c = swap_i & ~swap_q;
    assign accept_c    = swap_rise_c & en_i & (state == IDLE);

    assign rd_tag_c = '{vld:   rd_en_o,
                        first: rd_en_o && (addr_o == '0),
                        last:  rd_en_o && (addr_o == LAST_ADDR)};

`ifdef FRC_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        to_hit_c;

    assign to_hit_c = (to_cnt == 32'(TIMEOUT_CYC - 1));
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_in_100 or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            swap_q     <= 1'b0;
            flush_cnt  <= '0;
            addr_o     <= '0;
            rd_en_o    <= 1'b0;
            busy_o     <= 1'b0;
            drop_cnt_o <= '0;
`ifdef FRC_TIMEOUT_EN
            to_cnt     <= '0;
            timeout_o  <= 1'b0;
`endif
        end else begin
            swap_q <= swap_i;

            // Any rising swap that does not start a frame is a drop
            if (swap_rise_c && !accept_c && drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state   <= ISSUE;
                        addr_o  <= '0;
                        rd_en_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (addr_o == LAST_ADDR) begin
                        state     <= FLUSH;
                        rd_en_o   <= 1'b0;
                        flush_cnt <= '0;
                    end else begin
                        addr_o <= addr_o + ADDR_W'(1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state  <= DRAIN;
`ifdef FRC_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end else begin
                        flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (done_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
`ifdef FRC_TIMEOUT_EN
                    else if (to_hit_c) begin
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
`endif
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    frc_lat_pipe #(
        .LAT    (READ_LAT),
        .DATA_W (DATA_W)
    ) u_lat_pipe (
        .clk_in_100  (clk_in_100),
        .arst_n      (arst_n),
        .rd_tag      (rd_tag_c),
        .rdata       (rdata_i),
        .pix_valid   (pix_valid_o),
        .pix         (pix_o),
        .frame_start (frame_start_o),
        .frame_end   (frame_end_o)
    );

endmodule

// File: doc/frame_read_ctrl.md
Name: frame_read_ctrl

Overview:
- Frame-read sequencer sitting between the dual-BRAM frame store (pixel top) and the MaxPool → ZeroPad → Quantize chain.
- On each bank swap, issues F_SIZE sequential read addresses, then re-times the returned data by READ_LAT into a valid/pixel stream.
- Waits for the downstream end-of-frame before accepting the next swap; swaps that arrive while busy are counted and dropped.

Parameters:
- F_SIZE, 307200, pixels per frame (640x480).
- ADDR_W, 19, BRAM address width; requires 2^ADDR_W >= F_SIZE.
- DATA_W, 8, pixel width.
- READ_LAT, 1, BRAM read latency in cycles, legal range 1..4.
- TIMEOUT_CYC, 65536, drain watchdog limit in cycles; used only with FRC_TIMEOUT_EN.

Ports:
- clk_in_100  in  1  system clock, 100 MHz.
- arst_n  in  1  asynchronous active-low reset.
- en_i  in  1  arm; a swap is accepted only when 1.
- swap_i  in  1  bank-swap level from frame store; its rising edge marks a new frame.
- addr_o  out  ADDR_W  BRAM read address.
- rd_en_o  out  1  address valid this cycle.
- rdata_i  in  DATA_W  BRAM read data, valid READ_LAT cycles after rd_en_o.
- pix_valid_o  out  1  pixel strobe to MaxPool in_valid.
- pix_o  out  DATA_W  pixel to MaxPool in_pixel.
- frame_start_o  out  1  1-cycle pulse coincident with the first pix_valid_o of a frame.
- frame_end_o  out  1  1-cycle pulse coincident with the last (F_SIZE-th) pix_valid_o.
- done_i  in  1  downstream frame done (Quantize out_frame_last).
- busy_o  out  1  state != IDLE.
- drop_cnt_o  out  16  swaps ignored while busy or disarmed; saturates at 16'hFFFF.
- timeout_o  out  1  sticky watchdog flag; only with FRC_TIMEOUT_EN, otherwise tied 0.

Behaviour:
- Reset values, all outputs: addr_o=0, rd_en_o=0, pix_valid_o=0, pix_o=0, frame_start_o=0, frame_end_o=0, busy_o=0, drop_cnt_o=0, timeout_o=0. Internal: swap_q=0, state=IDLE.
- Edge detect: swap_rise = swap_i & ~swap_q, with swap_q registered every cycle.
- States:
  - IDLE: on swap_rise & en_i → ISSUE, with addr_o=0 and rd_en_o=1 registered on the next edge.
  - ISSUE: rd_en_o=1 every cycle; addr_o increments by 1 per cycle. When addr_o==F_SIZE-1 has been issued → FLUSH, rd_en_o=0.
  - FLUSH: hold for READ_LAT cycles while in-flight data returns → DRAIN.
  - DRAIN: wait for done_i → IDLE.
- Read pipeline: a READ_LAT-deep shift register of rd_en_o, plus a first/last tag per stage.
  - pix_valid_o = registered tap at READ_LAT; pix_o = rdata_i captured on the same edge.
  - Latency from rd_en_o to pix_valid_o is READ_LAT+1 cycles, fixed.
  - Exactly F_SIZE pix_valid_o pulses per accepted frame, on consecutive cycles, with no gaps.
- Address counter is ADDR_W wide and never wraps past F_SIZE-1.
- Drops: a swap_rise in any state other than IDLE, or in IDLE with en_i=0, increments drop_cnt_o and changes no state.
- done_i in IDLE, ISSUE or FLUSH is ignored. done_i in the same cycle as swap_rise in DRAIN: the state goes to IDLE and the swap counts as a drop.
- en_i deasserted mid-frame: the current frame completes; only new acceptances are blocked.
- Reset mid-frame: all state clears immediately and the partial frame is abandoned. Downstream blocks reset from the same source.
- Arithmetic is unsigned only; drop_cnt_o saturates rather than wrapping.

Optional Feature:
- FRC_TIMEOUT_EN defined:
  - A 32-bit counter runs while in DRAIN.
  - On reaching TIMEOUT_CYC: state forced to IDLE, timeout_o set (sticky until reset), counter cleared.
  - The counter clears on every DRAIN entry.
- Undefined: no counter is instantiated, timeout_o=0 constant, and DRAIN waits indefinitely.

Decomposition:
- Shared package frame_pkg:
  - constants H_ACTIVE=640, V_ACTIVE=480, F_SIZE, ADDR_FRAME=19, DATA_WIDTH=8, BLK=20, PAD=4.
  - state encoding frc_state_t {IDLE, ISSUE, FLUSH, DRAIN}.
- One natural sub-module: frc_lat_pipe, the parameterised READ_LAT valid/tag delay line with data capture.

Test Plan:
- Override F_SIZE=64, READ_LAT=1. Single swap_rise with en_i=1 → 64 rd_en_o cycles, addr 0..63. 64 contiguous pix_valid_o with pix_o==rdata_i. frame_start_o on pixel 0, frame_end_o on pixel 63. First pix_valid_o exactly 2 cycles after first rd_en_o.
- READ_LAT=3, BRAM model returning addr[7:0] → pix_o sequence 0..63 with no gaps. FLUSH lasts 3 cycles.
- Two swap_rise during ISSUE plus one during DRAIN → drop_cnt_o=3. Next swap after done_i accepted, second frame 64 pixels, counters unaffected.
- en_i=0 at swap_rise → no reads, drop_cnt_o=1. en_i dropped at pixel 30 of an active frame → frame still delivers 64 pixels.
- arst_n pulled low at address 20 → all outputs 0 within the same cycle. After release, a fresh swap restarts at addr 0.
- FRC_TIMEOUT_EN, TIMEOUT_CYC=100, done_i held 0 → at cycle 100 of DRAIN: state IDLE, timeout_o=1 and stays 1. Next swap accepted normally.
